// File: rtl/noc_pkg.sv
// Shared torus-router definitions: flit geometry, port directions, arbiter FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_pkg;

    localparam int FLIT_W    = 37;
    localparam int PORT_SIZE = FLIT_W + 2;   // flit + valid + ready on a link

    localparam int PORT_E     = 0;
    localparam int PORT_S     = 1;
    localparam int PORT_W     = 2;
    localparam int PORT_N     = 3;
    localparam int PORT_LOCAL = 4;
    localparam int NUM_DIRS   = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req_i scanning from ptr_i+1 upward, modulo N.
// Latency: purely combinational.
// Backpressure: none; vld_o low when nothing is requesting.
// Ports: req_i request vector, ptr_i index of last winner, grant_o one-hot winner, vld_o any winner.
module rr_pick #(
    parameter int N  = 5,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic          vld_o
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        // Offsets 1..N put the last winner at the lowest priority.
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign vld_o = found;

endmodule

// File: rtl/torus_out_arbiter.sv
// Per-output wormhole arbiter: round-robin grant held from head flit to tail flit.
// Latency: 1 cycle request-to-grant; flit path is a combinational mux (no flit register).
// Backpressure: ready_i gates ack_o for the owner only; non-owners wait with ack_o=0.
// Ports: req_i/tail_i/data_i per input, ack_o per input, grant_o owner one-hot,
//        data_o/valid_o/ready_i link side, busy_o link locked to a packet.
module torus_out_arbiter
    import noc_pkg::arb_state_t, noc_pkg::IDLE, noc_pkg::LOCKED, noc_pkg::NUM_DIRS;
#(
    parameter int IN_NUM = NUM_DIRS + 1,
    parameter int FLIT_W = noc_pkg::FLIT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IN_NUM-1:0]        req_i,
    input  logic [IN_NUM-1:0]        tail_i,
    input  logic [IN_NUM*FLIT_W-1:0] data_i,
    output logic [IN_NUM-1:0]        ack_o,
    output logic [IN_NUM-1:0]        grant_o,
    output logic [FLIT_W-1:0]        data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     busy_o
);

    localparam int IW = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;

    arb_state_t          state_q, state_d;
    logic [IN_NUM-1:0]   grant_q, grant_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       owner_idx;
    logic [IN_NUM-1:0]   pick_grant;
    logic                pick_vld;
    logic                locked;
    logic                xfer;
    logic [FLIT_W-1:0]   flit_arr [IN_NUM];

    for (genvar k = 0; k < IN_NUM; k++) begin : g_unpack
        assign flit_arr[k] = data_i[k*FLIT_W +: FLIT_W];
    end

    rr_pick #(
        .N  (IN_NUM),
        .PW (IW)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .vld_o   (pick_vld)
    );

    // Binary index of the current owner; grant_q is one-hot or zero.
    always_comb begin
        owner_idx = '0;
        for (int k = 0; k < IN_NUM; k++) begin
            if (grant_q[k]) begin
                owner_idx = IW'(k);
            end
        end
    end

    assign locked  = (state_q == LOCKED);
    assign valid_o = locked & req_i[owner_idx];
    assign xfer    = valid_o & ready_i;
    assign ack_o   = (locked && ready_i) ? (grant_q & req_i) : '0;
    assign data_o  = locked ? flit_arr[owner_idx] : '0;
    assign grant_o = grant_q;
    assign busy_o  = locked;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                // Grant only; the first flit moves on the following cycle.
                if (pick_vld) begin
                    grant_d = pick_grant;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // Owner stalls (req dropped) simply hold the lock.
                if (xfer && tail_i[owner_idx]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = owner_idx;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            // Last winner = IN_NUM-1 gives input 0 first priority after reset.
            ptr_q   <= IW'(IN_NUM - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_torus_out_arbiter.sv
module tb_torus_out_arbiter;

    localparam int N = 5;
    localparam int W = 37;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N-1:0]     tail;
    logic [N*W-1:0]   data_i;
    logic [N-1:0]     ack;
    logic [N-1:0]     grant;
    logic [W-1:0]     data_o;
    logic             valid;
    logic             ready;
    logic             busy;
    logic [W-1:0]     din [N];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign data_i[k*W +: W] = din[k];
    end

    torus_out_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req),
        .tail_i  (tail),
        .data_i  (data_i),
        .ack_o   (ack),
        .grant_o (grant),
        .data_o  (data_o),
        .valid_o (valid),
        .ready_i (ready),
        .busy_o  (busy)
    );

    int n_pass;
    int n_total;

    // Reference model: owner (-1 when the link is free) and last winner.
    int           m_owner;
    int           m_last;
    logic [N-1:0] exp_ack;

    // Random-phase source state.
    int           act  [N];
    int           len  [N];
    int           fidx [N];
    int           pid  [N];
    logic [N-1:0] r_req;
    logic [N-1:0] r_tail;

    function automatic logic [W-1:0] flit(input int k, input int p, input int i);
        return {3'(k), 18'(p), 16'(i)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] t, input logic rd);
        @(negedge clk);
        req   = r;
        tail  = t;
        ready = rd;
    endtask

    // Predict this cycle's outputs from the model, compare, then advance the
    // model to what the next rising edge should produce.
    task automatic cycle(input string tag);
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ack;
        logic [W-1:0] e_data;
        logic         e_valid;
        logic         e_busy;
        logic         found;
        int           w;
        #1;
        e_grant = '0;
        e_ack   = '0;
        e_data  = '0;
        e_valid = 1'b0;
        e_busy  = 1'b0;
        if (rst_n && m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_valid          = req[m_owner];
            e_data           = din[m_owner];
            e_busy           = 1'b1;
            if (req[m_owner] && ready) e_ack[m_owner] = 1'b1;
        end
        exp_ack = e_ack;
        chk({tag, "_grant"}, 64'(grant),  64'(e_grant));
        chk({tag, "_ack"},   64'(ack),    64'(e_ack));
        chk({tag, "_valid"}, 64'(valid),  64'(e_valid));
        chk({tag, "_data"},  64'(data_o), 64'(e_data));
        chk({tag, "_busy"},  64'(busy),   64'(e_busy));
        if (rst_n) begin
            if (m_owner < 0) begin
                found = 1'b0;
                for (int i = 1; i <= N; i++) begin
                    w = (m_last + i) % N;
                    if (!found && req[w]) begin
                        m_owner = w;
                        found   = 1'b1;
                    end
                end
            end else if (req[m_owner] && ready && tail[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_owner = -1;
        m_last  = N - 1;
        exp_ack = '0;
        rst_n   = 1'b0;
        req     = '0;
        tail    = '0;
        ready   = 1'b0;
        for (int k = 0; k < N; k++) din[k] = flit(k, 1, 0);

        // Reset state.
        @(negedge clk);
        cycle("rst");

        // All five requesting, single-flit packets; then 0 and 3 with last winner 4.
        for (int i = 0; i < 12; i++) begin
            drive((i >= 10) ? 5'b01001 : 5'b11111, 5'b11111, 1'b1);
            if (i == 0) rst_n = 1'b1;
            cycle("rr");
            chk("rr_order", 64'(grant), (i % 2 == 0) ? 64'd0 : (64'd1 << ((i / 2) % N)));
        end

        // Single 3-flit packet on input 2.
        din[2] = flit(2, 2, 0);
        drive(5'b00100, 5'b00000, 1'b1); cycle("a_arb");
        drive(5'b00100, 5'b00000, 1'b1); cycle("a_f0");
        chk("a_grant", 64'(grant), 64'b00100);
        din[2] = flit(2, 2, 1);
        drive(5'b00100, 5'b00000, 1'b1); cycle("a_f1");
        chk("a_data1", 64'(data_o), 64'(flit(2, 2, 1)));
        din[2] = flit(2, 2, 2);
        drive(5'b00100, 5'b00100, 1'b1); cycle("a_f2");
        for (int k = 0; k < N; k++) din[k] = flit(k, 3, 0);
        drive(5'b11011, 5'b00000, 1'b1); cycle("a_after");
        chk("a_busy_drop", 64'(busy), 64'd0);
        // Last winner 2 means input 3 is next in line.
        drive(5'b11011, 5'b00000, 1'b1); cycle("ptr2");
        chk("ptr2_grant", 64'(grant), 64'b01000);

        // Asynchronous reset mid-packet, between clock edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", 64'(grant),  64'd0);
        chk("arst_ack",   64'(ack),    64'd0);
        chk("arst_valid", 64'(valid),  64'd0);
        chk("arst_data",  64'(data_o), 64'd0);
        chk("arst_busy",  64'(busy),   64'd0);
        m_owner = -1;
        m_last  = N - 1;
        drive(5'b11011, 5'b00001, 1'b1); cycle("arst_hold");
        drive(5'b11011, 5'b00001, 1'b1); rst_n = 1'b1; cycle("rel_arb");
        drive(5'b11011, 5'b00001, 1'b1); cycle("rel_gnt");
        chk("rel_grant", 64'(grant), 64'b00001);

        // Back-pressure on owner 3 with input 0 waiting.
        din[3] = flit(3, 4, 0);
        din[0] = flit(0, 4, 0);
        drive(5'b01000, 5'b00000, 1'b1); cycle("bp_arb");
        drive(5'b01000, 5'b00000, 1'b1); cycle("bp_f0");
        chk("bp_grant0", 64'(grant), 64'b01000);
        din[3] = flit(3, 4, 1);
        for (int i = 0; i < 4; i++) begin
            drive(5'b01001, 5'b00001, 1'b0); cycle("bp_stall");
            chk("bp_valid", 64'(valid),  64'd1);
            chk("bp_ack",   64'(ack),    64'd0);
            chk("bp_data",  64'(data_o), 64'(flit(3, 4, 1)));
            chk("bp_lock",  64'(grant),  64'b01000);
        end
        drive(5'b01001, 5'b00001, 1'b1); cycle("bp_f1");
        chk("bp_resume", 64'(ack), 64'b01000);
        din[3] = flit(3, 4, 2);
        drive(5'b01001, 5'b01001, 1'b1); cycle("bp_tail");
        drive(5'b00001, 5'b00001, 1'b1); cycle("bp_bubble");
        chk("bp_bubble_gnt", 64'(grant), 64'd0);
        drive(5'b00001, 5'b00001, 1'b1); cycle("bp_next");
        chk("bp_next_gnt", 64'(grant), 64'b00001);

        // Owner 1 drops its request mid-packet while input 2 waits.
        din[1] = flit(1, 5, 0);
        din[2] = flit(2, 5, 0);
        drive(5'b00010, 5'b00000, 1'b1); cycle("st_arb");
        drive(5'b00010, 5'b00000, 1'b1); cycle("st_f0");
        din[1] = flit(1, 5, 1);
        for (int i = 0; i < 3; i++) begin
            drive(5'b00100, 5'b00100, 1'b1); cycle("st_stall");
            chk("st_valid", 64'(valid), 64'd0);
            chk("st_lock",  64'(grant), 64'b00010);
        end
        drive(5'b00110, 5'b00110, 1'b1); cycle("st_tail");
        chk("st_tail_ack", 64'(ack), 64'b00010);
        drive(5'b00100, 5'b00100, 1'b1); cycle("st_bubble");
        chk("st_bubble_gnt", 64'(grant), 64'd0);
        drive(5'b00100, 5'b00100, 1'b1); cycle("st_next");
        chk("st_next_gnt", 64'(grant), 64'b00100);

        // Random traffic: variable-length packets, random ready, owner stalls.
        for (int k = 0; k < N; k++) begin
            act[k]  = 0;
            len[k]  = 1;
            fidx[k] = 0;
            pid[k]  = 100;
        end
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (act[k] == 0 && $urandom_range(3) == 0) begin
                    act[k]  = 1;
                    len[k]  = int'($urandom_range(4, 1));
                    fidx[k] = 0;
                    pid[k]  = pid[k] + 1;
                end
                r_req[k]  = (act[k] != 0);
                // Only the current owner may drop its request mid-packet.
                if (k == m_owner && act[k] != 0 && $urandom_range(4) == 0) r_req[k] = 1'b0;
                r_tail[k] = (act[k] != 0) && (fidx[k] == len[k] - 1);
                din[k]    = flit(k, pid[k], fidx[k]);
            end
            req   = r_req;
            tail  = r_tail;
            ready = ($urandom_range(3) != 0);
            cycle("rnd");
            for (int k = 0; k < N; k++) begin
                if (exp_ack[k]) begin
                    fidx[k] = fidx[k] + 1;
                    if (fidx[k] == len[k]) act[k] = 0;
                end
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
